alu_core: RTL and testbench

Registered 4-bit arithmetic/logic unit with an 8-bit result. Two 4-bit unsigned operands `a` and `b` and a 3-bit opcode `s` are sampled on a clock edge when `en` is high. The result appears on `y` one cycle later. It sits in the datapath as a single-cycle execute stage feeding an 8-bit result bus.

---
 rtl/alu_core.sv | 88 ++++++++
 tb/tb_alu_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered 4-bit ALU execute stage producing an 8-bit result one cycle after capture.
// Optional status flags (zero, neg) are built when ALU_FLAGS_EN is defined.
module alu_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] s,
    output logic [7:0] y,
    output logic       valid
`ifdef ALU_FLAGS_EN
    ,
    output logic       zero,
    output logic       neg
`endif
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    logic [RES_W-1:0] a_ext_c;
    logic [RES_W-1:0] b_ext_c;
    logic [OP_W-1:0]  logic_c;
    logic [RES_W-1:0] result_c;

    assign a_ext_c = RES_W'(a);
    assign b_ext_c = RES_W'(b);

    // Logic ops stay 4 bits wide so the upper nibble of the result is always zero.
    always_comb begin
        logic_c = '0;
        case (s)
            OP_AND:  logic_c = a & b;
            OP_OR:   logic_c = a | b;
            OP_XOR:  logic_c = a ^ b;
            OP_NOR:  logic_c = ~(a | b);
            OP_XNOR: logic_c = ~(a ^ b);
            default: logic_c = '0;
        endcase
    end

    always_comb begin
        result_c = '0;
        case (s)
            OP_ADD:  result_c = a_ext_c + b_ext_c;
            OP_SUB:  result_c = a_ext_c - b_ext_c;
            OP_MUL:  result_c = a_ext_c * b_ext_c;
            default: result_c = RES_W'(logic_c);
        endcase
    end

    // Result register: captures on en, holds otherwise; valid marks a fresh result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                y <= result_c;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    // Flags follow y exactly; neg only reports a borrow out of subtraction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (en) begin
            zero <= (result_c == '0);
            neg  <= (s == OP_SUB) && (a < b);
        end
    end
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed opcode table, extremes, hold, back-to-back
// and randomized traffic against an arithmetic reference model.
module tb_alu_core;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic [7:0] y;
    logic       valid;
`ifdef ALU_FLAGS_EN
    logic       zero;
    logic       neg;
`endif

    int vectors;
    int miscompares;

    logic [7:0] exp_y;
    logic       exp_valid;
    logic       exp_zero;
    logic       exp_neg;

    alu_core dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .b     (b),
        .s     (s),
        .y     (y),
        .valid (valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero  (zero),
        .neg   (neg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the opcode table using plain integer arithmetic.
    function automatic logic [7:0] model(input int ia, input int ib, input int is);
        int r;
        case (is)
            0: r = ia + ib;
            1: r = (ia - ib + 256) % 256;
            2: r = ia * ib;
            3: r = ia & ib;
            4: r = ia | ib;
            5: r = ia ^ ib;
            6: r = 15 - (ia | ib);
            default: r = 15 - (ia ^ ib);
        endcase
        return 8'(r);
    endfunction

    // Applies inputs, updates expectations, and advances to just after the next rising edge.
    task automatic drive(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] is,
                         input logic ien);
        a  = ia;
        b  = ib;
        s  = is;
        en = ien;
        exp_valid = ien;
        if (ien) begin
            exp_y    = model(int'(ia), int'(ib), int'(is));
            exp_zero = (exp_y == 8'h00);
            exp_neg  = (is == 3'd1) && (ia < ib);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(4'h9, 4'h3, 3'd0, 1'b1);
        vectors++;
        if (y !== 8'h0C) begin
            miscompares++;
            $display("FAIL reset_pre y got %h want 0C", y);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (y !== 8'h00 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async y/valid got %h/%b want 00/0", y, valid);
        end
`ifdef ALU_FLAGS_EN
        vectors++;
        if (zero !== 1'b0 || neg !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags zero/neg got %b/%b want 0/0", zero, neg);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        exp_y = 8'h00;
        exp_zero = 1'b0;
        exp_neg = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 4'hF, 3'd2, 1'b0);
            vectors++;
            if (y !== 8'h00 || valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d] y/valid got %h/%b want 00/0", i, y, valid);
            end
        end
    endtask

    task automatic test_opcodes();
        logic [3:0] ta [11];
        logic [3:0] tb [11];
        logic [2:0] ts [11];
        logic [7:0] ty [11];
        ta = '{4'b1001, 4'b1001, 4'b1001, 4'b1101, 4'b1011, 4'b1010, 4'b1110, 4'b0101,
               4'hF, 4'hF, 4'h0};
        tb = '{4'b0011, 4'b1011, 4'b0111, 4'b1011, 4'b0111, 4'b1011, 4'b0111, 4'b1011,
               4'hF, 4'hF, 4'hF};
        ts = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd0, 3'd1};
        ty = '{8'h0C, 8'hFE, 8'h3F, 8'h09, 8'h0F, 8'h01, 8'h00, 8'h01, 8'hE1, 8'h1E, 8'hF1};
        for (int i = 0; i < 11; i++) begin
            drive(ta[i], tb[i], ts[i], 1'b1);
            vectors++;
            if (y !== ty[i] || valid !== 1'b1) begin
                miscompares++;
                $display("FAIL opcode[%0d] s=%0d y/valid got %h/%b want %h/1",
                         i, ts[i], y, valid, ty[i]);
            end
`ifdef ALU_FLAGS_EN
            vectors++;
            if (zero !== (ty[i] == 8'h00) || neg !== (ts[i] == 3'd1 && ta[i] < tb[i])) begin
                miscompares++;
                $display("FAIL opcode_flags[%0d] zero/neg got %b/%b want %b/%b", i, zero, neg,
                         ty[i] == 8'h00, ts[i] == 3'd1 && ta[i] < tb[i]);
            end
`endif
        end
    endtask

    task automatic test_hold();
        drive(4'hD, 4'h6, 3'd2, 1'b1);
        vectors++;
        if (y !== 8'h4E) begin
            miscompares++;
            $display("FAIL hold_capture y got %h want 4E", y);
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'($urandom), 4'($urandom), 3'($urandom), 1'b0);
            vectors++;
            if (y !== 8'h4E || valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d] y/valid got %h/%b want 4E/0", i, y, valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(4'($urandom), 4'($urandom), 3'(i), 1'b1);
            vectors++;
            if (y !== exp_y || valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b[%0d] y/valid got %h/%b want %h/1", i, y, valid, exp_y);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(4'($urandom), 4'($urandom), 3'($urandom), ($urandom_range(3, 0) != 0));
            vectors++;
            if (y !== exp_y || valid !== exp_valid) begin
                miscompares++;
                $display("FAIL random[%0d] y/valid got %h/%b want %h/%b",
                         i, y, valid, exp_y, exp_valid);
            end
`ifdef ALU_FLAGS_EN
            vectors++;
            if (zero !== exp_zero || neg !== exp_neg) begin
                miscompares++;
                $display("FAIL random_flags[%0d] zero/neg got %b/%b want %b/%b",
                         i, zero, neg, exp_zero, exp_neg);
            end
`endif
        end
    endtask

    task automatic test_flags();
        drive(4'h3, 4'h3, 3'd1, 1'b1);
        vectors++;
        if (y !== 8'h00) begin
            miscompares++;
            $display("FAIL flags_y got %h want 00", y);
        end
`ifdef ALU_FLAGS_EN
        vectors++;
        if (zero !== 1'b1 || neg !== 1'b0) begin
            miscompares++;
            $display("FAIL flags zero/neg got %b/%b want 1/0", zero, neg);
        end
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_y = 8'h00;
        exp_valid = 1'b0;
        exp_zero = 1'b0;
        exp_neg = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        a = '0;
        b = '0;
        s = '0;
        #1;
        vectors++;
        if (y !== 8'h00 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL power_on_reset y/valid got %h/%b want 00/0", y, valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_opcodes();
        test_hold();
        test_back_to_back();
        test_flags();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
